// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronizes and deglitches the PS/2 pins, receives
// 11-bit frames and folds E0/F0 prefixes into single make/break key events.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] to_cnt;

  logic          ext_flag, brk_flag;

  // Synchronizers idle high like the bus; the filtered clock only follows the
  // synchronized pin after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      data_s1    <= 1'b1;
      data_s2    <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      data_s1    <= ps2_data;
      data_s2    <= data_s1;
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // Frame receiver; the timeout counter only runs while a frame is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !data_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_s2;
            state <= STOP;
          end
          default: begin
            if ((^{shift, par}) && data_s2) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Prefix bytes only arm flags; the next non-prefix byte emits the event.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_code  <= rx_byte;
          key_ext   <= ext_flag;
          key_break <= brk_flag;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, pulse counting
// monitor, expected values worked out by hand for each frame.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_valid, frame_err, key_ext, key_break, key_valid;

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int rxCount = 0, errCount = 0, keyCount = 0;
  int rxCycle = 0, keyCycle = 0;
  logic [7:0] lastRx = 8'h00, lastKey = 8'h00;
  logic lastExt = 1'b0, lastBrk = 1'b0, overlap = 1'b0;

  int rxBase, errBase, keyBase;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Every high cycle of a pulse is counted, so a stretched pulse shows up as an
  // extra count.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (rx_valid && frame_err) overlap <= 1'b1;
    if (rx_valid) begin
      rxCount <= rxCount + 1;
      rxCycle <= cycle;
      lastRx  <= rx_byte;
    end
    if (frame_err) errCount <= errCount + 1;
    if (key_valid) begin
      keyCount <= keyCount + 1;
      keyCycle <= cycle;
      lastKey  <= key_code;
      lastExt  <= key_ext;
      lastBrk  <= key_break;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends the first nbits bits of a frame; data changes mid clock-high.
  task automatic applyStimulus(input logic [7:0] b, input logic badPar,
                               input logic stopBit, input int period,
                               input int nbits);
    logic [10:0] bits;
    bits = {stopBit, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      waitCycles(period / 4);
      ps2_clk = 1'b0;
      waitCycles(period / 2);
      ps2_clk = 1'b1;
      waitCycles(period / 4);
    end
    ps2_data = 1'b1;
    waitCycles(60);
  endtask

  task automatic snapshot();
    rxBase  = rxCount;
    errBase = errCount;
    keyBase = keyCount;
  endtask

  initial begin
    waitCycles(4);
    checkOutput("reset_rx_byte", rx_byte, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_key_code", key_code, 0);
    checkOutput("reset_key_ext", key_ext, 0);
    checkOutput("reset_key_break", key_break, 0);
    checkOutput("reset_key_valid", key_valid, 0);
    reset = 1'b0;
    waitCycles(20);

    snapshot();
    applyStimulus(8'h29, 1'b0, 1'b1, 1500, 11);
    checkOutput("f29_rx_count", rxCount - rxBase, 1);
    checkOutput("f29_rx_byte", lastRx, 8'h29);
    checkOutput("f29_key_count", keyCount - keyBase, 1);
    checkOutput("f29_key_latency", keyCycle - rxCycle, 1);
    checkOutput("f29_key", {lastExt, lastBrk, lastKey}, {2'b00, 8'h29});
    checkOutput("f29_hold_code", key_code, 8'h29);

    snapshot();
    applyStimulus(8'hF0, 1'b0, 1'b1, 200, 11);
    checkOutput("f0_no_key", keyCount - keyBase, 0);
    applyStimulus(8'h29, 1'b0, 1'b1, 200, 11);
    checkOutput("brk_rx_count", rxCount - rxBase, 2);
    checkOutput("brk_key_count", keyCount - keyBase, 1);
    checkOutput("brk_key", {lastExt, lastBrk, lastKey}, {2'b01, 8'h29});

    snapshot();
    applyStimulus(8'hE0, 1'b0, 1'b1, 200, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 200, 11);
    applyStimulus(8'h75, 1'b0, 1'b1, 200, 11);
    checkOutput("ext_key_count", keyCount - keyBase, 1);
    checkOutput("ext_key", {lastExt, lastBrk, lastKey}, {2'b11, 8'h75});
    applyStimulus(8'h1D, 1'b0, 1'b1, 200, 11);
    checkOutput("clr_key_count", keyCount - keyBase, 2);
    checkOutput("clr_key", {lastExt, lastBrk, lastKey}, {2'b00, 8'h1D});

    snapshot();
    applyStimulus(8'h1D, 1'b1, 1'b1, 200, 11);
    checkOutput("par_err_count", errCount - errBase, 1);
    checkOutput("par_rx_count", rxCount - rxBase, 0);
    checkOutput("par_key_count", keyCount - keyBase, 0);
    applyStimulus(8'h1D, 1'b0, 1'b0, 200, 11);
    checkOutput("stop_err_count", errCount - errBase, 2);
    checkOutput("stop_rx_count", rxCount - rxBase, 0);
    applyStimulus(8'h5A, 1'b0, 1'b1, 200, 11);
    checkOutput("5a_rx_count", rxCount - rxBase, 1);
    checkOutput("5a_rx_byte", lastRx, 8'h5A);
    checkOutput("5a_key", {lastExt, lastBrk, lastKey}, {2'b00, 8'h5A});

    // A glitch with data low would look like a start bit if it got through.
    snapshot();
    ps2_data = 1'b0;
    waitCycles(5);
    ps2_clk = 1'b0;
    waitCycles(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    waitCycles(5);
    ps2_data = 1'b1;
    waitCycles(50);
    applyStimulus(8'h6B, 1'b0, 1'b1, 200, 11);
    checkOutput("glitch_err_count", errCount - errBase, 0);
    checkOutput("glitch_rx_byte", lastRx, 8'h6B);
    checkOutput("glitch_rx_count", rxCount - rxBase, 1);

    snapshot();
    applyStimulus(8'h1B, 1'b0, 1'b1, 200, 6);
    checkOutput("trunc_no_err_early", errCount - errBase, 0);
    waitCycles(TIMEOUT + 10);
    checkOutput("timeout_err_count", errCount - errBase, 1);
    checkOutput("timeout_rx_count", rxCount - rxBase, 0);
    applyStimulus(8'h1B, 1'b0, 1'b1, 200, 11);
    checkOutput("after_to_rx_count", rxCount - rxBase, 1);
    checkOutput("after_to_rx_byte", lastRx, 8'h1B);

    snapshot();
    applyStimulus(8'h1B, 1'b0, 1'b1, 200, 5);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(TIMEOUT + 10);
    checkOutput("rst_no_pulses", (rxCount - rxBase) + (errCount - errBase) + (keyCount - keyBase), 0);
    checkOutput("rst_rx_byte", rx_byte, 0);
    checkOutput("rst_key_code", key_code, 0);
    applyStimulus(8'h1B, 1'b0, 1'b1, 200, 11);
    checkOutput("rst_rx_count", rxCount - rxBase, 1);
    checkOutput("rst_rx_byte_after", lastRx, 8'h1B);
    checkOutput("rst_key_count", keyCount - keyBase, 1);
    checkOutput("rst_key", {lastExt, lastBrk, lastKey}, {2'b00, 8'h1B});
    checkOutput("rst_err_count", errCount - errBase, 0);

    checkOutput("no_rx_err_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
